// File: rtl/fetch_lane_fifo.sv
// Fetch-block FIFO with per-lane valids, taken-branch squash and per-lane retire.
// Optional same-cycle empty-FIFO bypass when FETCH_LANE_FIFO_BYPASS_EN is defined.
module fetch_lane_fifo #(
  parameter int DEPTH  = 4,
  parameter int LANES  = 2,
  parameter int INFO_W = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic [31:0]               pc_in_i,
  input  logic [LANES-1:0]          lane_valid_in_i,
  input  logic [LANES-1:0]          pred_in_i,
  input  logic [32*LANES-1:0]       data_in_i,
  input  logic [INFO_W*LANES-1:0]   info_in_i,
  output logic                      accept_o,
  output logic [LANES-1:0]          valid_o,
  output logic [32*LANES-1:0]       pc_o,
  output logic [32*LANES-1:0]       data_o,
  output logic [INFO_W*LANES-1:0]   info_o,
  input  logic [LANES-1:0]          pop_i,
  output logic [$clog2(DEPTH):0]    level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LB = $clog2(4*LANES);
  localparam int DW = 32*LANES;
  localparam int IW = INFO_W*LANES;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [LANES-1:0] r_valid [DEPTH];
  logic [DW-1:0]    r_data  [DEPTH];
  logic [IW-1:0]    r_info  [DEPTH];
  logic [31:LB]     r_pc    [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;

  logic [LANES-1:0] w_mask;
  logic             w_empty;
  logic             w_accept;
  logic             w_push;
  logic             w_bypass;
  logic [LANES-1:0] w_head_valid;
  logic [31:LB]     w_pc_hi;
  logic [LANES-1:0] w_pop_eff;
  logic [LANES-1:0] w_remain;
  logic             w_retire;
  logic             w_store;
  logic [LANES-1:0] w_store_mask;
  logic             w_unused_pc_lsb;

  // Lanes after the first valid predicted-taken lane belong to the wrong path.
  always_comb begin
    logic taken;
    taken  = 1'b0;
    w_mask = '0;
    for (int k = 0; k < LANES; k++) begin
      w_mask[k] = lane_valid_in_i[k] & ~taken;
      taken     = taken | (lane_valid_in_i[k] & pred_in_i[k]);
    end
  end

  assign w_unused_pc_lsb = ^pc_in_i[LB-1:0];

  assign w_empty  = (r_level == '0);
  assign w_accept = (r_level != LVL_FULL);
  assign w_push   = push_i & w_accept & ~flush_i & (|w_mask);

`ifdef FETCH_LANE_FIFO_BYPASS_EN
  assign w_bypass = w_empty & w_push;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_head_valid = w_empty ? '0 : r_valid[r_rd_ptr];
  assign valid_o      = w_bypass ? w_mask : w_head_valid;
  assign data_o       = w_bypass ? data_in_i : r_data[r_rd_ptr];
  assign info_o       = w_bypass ? info_in_i : r_info[r_rd_ptr];
  assign w_pc_hi      = w_bypass ? pc_in_i[31:LB] : r_pc[r_rd_ptr];

  for (genvar k = 0; k < LANES; k++) begin : g_lane_pc
    assign pc_o[32*k +: 32] = {w_pc_hi, LB'(4*k)};
  end

  assign w_pop_eff    = pop_i & valid_o;
  assign w_remain     = valid_o & ~w_pop_eff;
  assign w_retire     = ~w_empty & (|w_pop_eff) & (w_remain == '0);
  // A bypassed entry fully consumed in its arrival cycle never occupies a slot.
  assign w_store      = w_push & ~(w_bypass & (w_remain == '0));
  assign w_store_mask = w_bypass ? w_remain : w_mask;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= '0;
        r_data[i]  <= '0;
        r_info[i]  <= '0;
        r_pc[i]    <= '0;
      end
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= '0;
        r_info[i]  <= '0;
      end
    end else begin
      if (!w_empty) begin
        r_valid[r_rd_ptr] <= w_remain;
      end
      if (w_retire) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_store) begin
        r_valid[r_wr_ptr] <= w_store_mask;
        r_data[r_wr_ptr]  <= data_in_i;
        r_info[r_wr_ptr]  <= info_in_i;
        r_pc[r_wr_ptr]    <= pc_in_i[31:LB];
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      case ({w_store, w_retire})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign accept_o = w_accept;
  assign level_o  = r_level;

endmodule

// File: tb/tb_fetch_lane_fifo.sv
// Randomized bench for fetch_lane_fifo against a queue-based entry model.
// Expectations follow FETCH_LANE_FIFO_BYPASS_EN when it is defined for the build.
module tb_fetch_lane_fifo;

  localparam int DEPTH  = 4;
  localparam int LANES  = 2;
  localparam int INFO_W = 2;
  localparam int LB     = $clog2(4*LANES);

  logic                    clk_sys;
  logic                    rst_ni;
  logic                    flush_i;
  logic                    push_i;
  logic [31:0]             pc_in_i;
  logic [LANES-1:0]        lane_valid_in_i;
  logic [LANES-1:0]        pred_in_i;
  logic [32*LANES-1:0]     data_in_i;
  logic [INFO_W*LANES-1:0] info_in_i;
  logic                    accept_o;
  logic [LANES-1:0]        valid_o;
  logic [32*LANES-1:0]     pc_o;
  logic [32*LANES-1:0]     data_o;
  logic [INFO_W*LANES-1:0] info_o;
  logic [LANES-1:0]        pop_i;
  logic [$clog2(DEPTH):0]  level_o;

  int n_chk;
  int n_fail;

  typedef struct packed {
    logic [31:0]             pc;
    logic [LANES-1:0]        m;
    logic [32*LANES-1:0]     d;
    logic [INFO_W*LANES-1:0] i;
  } ent_t;

  ent_t q[$];

  fetch_lane_fifo #(.DEPTH(DEPTH), .LANES(LANES), .INFO_W(INFO_W)) u_dut (
    .clk_i           (clk_sys),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .push_i          (push_i),
    .pc_in_i         (pc_in_i),
    .lane_valid_in_i (lane_valid_in_i),
    .pred_in_i       (pred_in_i),
    .data_in_i       (data_in_i),
    .info_in_i       (info_in_i),
    .accept_o        (accept_o),
    .valid_o         (valid_o),
    .pc_o            (pc_o),
    .data_o          (data_o),
    .info_o          (info_o),
    .pop_i           (pop_i),
    .level_o         (level_o)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Valid lanes up to and including the first valid predicted-taken lane.
  function automatic logic [LANES-1:0] lane_mask(input logic [LANES-1:0] lv, input logic [LANES-1:0] pr);
    logic [LANES-1:0] m;
    m = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lv[k]) begin
        m[k] = 1'b1;
        if (pr[k]) break;
      end
    end
    return m;
  endfunction

  function automatic logic [32*LANES-1:0] pc_vec(input logic [31:0] pc);
    logic [32*LANES-1:0] v;
    for (int k = 0; k < LANES; k++) v[32*k +: 32] = ((pc >> LB) << LB) + 32'(4*k);
    return v;
  endfunction

  task automatic idle();
    flush_i = 1'b0;
    push_i  = 1'b0;
    pop_i   = '0;
  endtask

  task automatic cyc(input logic fl, input logic pu, input logic [31:0] pc,
                     input logic [LANES-1:0] lv, input logic [LANES-1:0] pr,
                     input logic [LANES-1:0] po);
    ent_t in, cur, h;
    logic [LANES-1:0] exp_v, eff;
    logic push_ok, bypass_now, have;
    @(negedge clk_sys);
    flush_i         = fl;
    push_i          = pu;
    pc_in_i         = pc;
    lane_valid_in_i = lv;
    pred_in_i       = pr;
    pop_i           = po;
    data_in_i       = {$urandom, $urandom};
    info_in_i       = INFO_W*LANES'($urandom);
    #1;
    in.pc = pc;
    in.m  = lane_mask(lv, pr);
    in.d  = data_in_i;
    in.i  = info_in_i;
    push_ok    = pu && !fl && (q.size() < DEPTH) && (in.m != '0);
    bypass_now = 1'b0;
`ifdef FETCH_LANE_FIFO_BYPASS_EN
    bypass_now = push_ok && (q.size() == 0);
`endif
    chk("level", 128'(level_o), 128'(q.size()));
    chk("accept", 128'(accept_o), 128'(q.size() != DEPTH));
    have = 1'b1;
    cur  = '0;
    if (bypass_now) cur = in;
    else if (q.size() > 0) cur = q[0];
    else have = 1'b0;
    exp_v = have ? cur.m : '0;
    chk("valid", 128'(valid_o), 128'(exp_v));
    if (have) begin
      chk("data", 128'(data_o), 128'(cur.d));
      chk("info", 128'(info_o), 128'(cur.i));
      chk("pc", 128'(pc_o), 128'(pc_vec(cur.pc)));
    end
    @(posedge clk_sys);
    if (fl) begin
      q.delete();
    end else begin
      eff = po & exp_v;
      if (bypass_now) begin
        if ((in.m & ~eff) != '0) begin
          in.m = in.m & ~eff;
          q.push_back(in);
        end
      end else begin
        if (q.size() > 0) begin
          h   = q[0];
          h.m = h.m & ~eff;
          if (h.m == '0) void'(q.pop_front());
          else q[0] = h;
        end
        if (push_ok) q.push_back(in);
      end
    end
    #1;
    idle();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_ni = 1'b0;
    idle();
    pc_in_i = '0; lane_valid_in_i = '0; pred_in_i = '0; data_in_i = '0; info_in_i = '0;
    repeat (2) @(posedge clk_sys);
    #1;
    chk("rst_level", 128'(level_o), 128'(0));
    chk("rst_valid", 128'(valid_o), 128'(0));
    chk("rst_accept", 128'(accept_o), 128'(1));
    @(negedge clk_sys);
    rst_ni = 1'b1;

    // Taken branch in lane 0 squashes lane 1.
    cyc(0, 1, 32'h1000, 2'b11, 2'b01, 2'b00);
    chk("sq_level", 128'(level_o), 128'(1));
    chk("sq_valid", 128'(valid_o), 128'(2'b01));
    chk("sq_pc0", 128'(pc_o[31:0]), 128'(32'h1000));
    cyc(0, 0, 0, 2'b00, 2'b00, 2'b01);
    chk("sq_retire", 128'(level_o), 128'(0));

    // Fill, overflow push, then free a slot.
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 32'h2000 + 32'(8*i), 2'b11, 2'b00, 2'b00);
    chk("full_level", 128'(level_o), 128'(DEPTH));
    chk("full_accept", 128'(accept_o), 128'(0));
    cyc(0, 1, 32'h3000, 2'b11, 2'b00, 2'b00);
    chk("ovf_level", 128'(level_o), 128'(DEPTH));
    cyc(0, 0, 0, 2'b00, 2'b00, 2'b11);
    chk("free_accept", 128'(accept_o), 128'(1));

    // Split pops retire on the last lane; joint pop retires at once.
    cyc(0, 0, 0, 2'b00, 2'b00, 2'b10);
    chk("split1_level", 128'(level_o), 128'(3));
    chk("split1_valid", 128'(valid_o), 128'(2'b01));
    cyc(0, 0, 0, 2'b00, 2'b00, 2'b01);
    chk("split2_level", 128'(level_o), 128'(2));
    cyc(0, 0, 0, 2'b00, 2'b00, 2'b11);
    chk("joint_level", 128'(level_o), 128'(1));

    // Flush beats simultaneous push and pop.
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'h4000 + 32'(8*i), 2'b11, 2'b00, 2'b00);
    chk("refill_level", 128'(level_o), 128'(DEPTH));
    cyc(1, 1, 32'h5000, 2'b11, 2'b00, 2'b11);
    chk("flush_level", 128'(level_o), 128'(0));
    chk("flush_valid", 128'(valid_o), 128'(0));

    // Streaming across pointer wrap.
    cyc(0, 1, 32'h6000, 2'b11, 2'b00, 2'b00);
    for (int i = 1; i <= 3*DEPTH; i++) begin
      cyc(0, 1, 32'h6000 + 32'(8*i), 2'b11, 2'b00, 2'b11);
      chk("stream_level", 128'(level_o), 128'(1));
    end
    cyc(0, 0, 0, 2'b00, 2'b00, 2'b11);

    // Push and full pop into an empty FIFO.
    cyc(0, 1, 32'h7000, 2'b11, 2'b00, 2'b11);
`ifdef FETCH_LANE_FIFO_BYPASS_EN
    chk("empty_pushpop_level", 128'(level_o), 128'(0));
`else
    chk("empty_pushpop_level", 128'(level_o), 128'(1));
`endif
    cyc(0, 0, 0, 2'b00, 2'b00, 2'b11);

    // Asynchronous reset in the middle of traffic.
    cyc(0, 1, 32'h8000, 2'b10, 2'b00, 2'b00);
    cyc(0, 1, 32'h8008, 2'b11, 2'b10, 2'b00);
    rst_ni = 1'b0;
    #2;
    chk("amid_level", 128'(level_o), 128'(0));
    chk("amid_valid", 128'(valid_o), 128'(0));
    chk("amid_accept", 128'(accept_o), 128'(1));
    q.delete();
    @(negedge clk_sys);
    rst_ni = 1'b1;

    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6), $urandom,
          LANES'($urandom), (($urandom_range(0, 2) == 0) ? LANES'($urandom) : '0),
          LANES'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
